// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports, optional bypass
// and a sequenced clear engine. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr0_en,
    input  logic [AW-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [AW-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    output logic                     wr_ready,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              we0, we1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_ready  = 1'b1;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                wr_ready  = 1'b0;
                clr_busy  = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d   = DONE;
                    clr_idx_d = '0;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // wr0 loses to wr1 on a shared address even when wr1 itself is discarded (zero register)
    assign we1 = wr1_en && wr_ready && !(ZERO_REG && (wr1_addr == '0));
    assign we0 = wr0_en && wr_ready && !(ZERO_REG && (wr0_addr == '0))
                 && !(wr1_en && (wr1_addr == wr0_addr));

    always_comb begin
        regs_d = regs_q;
        if (we0) regs_d[wr0_addr] = wr0_data;
        if (we1) regs_d[wr1_addr] = wr1_data;
        if (state_q == CLEAR) regs_d[clr_idx_q] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*AW +: AW]];
            if (BYPASS != 0) begin
                if (we1 && (wr1_addr == rd_addr[k*AW +: AW]))
                    rd_data[k*DATA_W +: DATA_W] = wr1_data;
                else if (we0 && (wr0_addr == rd_addr[k*AW +: AW]))
                    rd_data[k*DATA_W +: DATA_W] = wr0_data;
            end
            if (ZERO_REG && (rd_addr[k*AW +: AW] == '0))
                rd_data[k*DATA_W +: DATA_W] = '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: vector table, directed clear/reset sequences and random traffic
// checked against a behavioural model of regfile_mp (honours REGFILE_ZERO_REG_EN).
module tb_regfile_mp;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned AW     = 5;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    localparam logic [31:0] R0V = ZR ? 32'h0 : 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr0_en, wr1_en, clr_req;
    logic [AW-1:0]     wr0_addr, wr1_addr, rd0, rd1;
    logic [31:0]       wr0_data, wr1_data;
    logic [2*AW-1:0]   rd_addr;
    logic [63:0]       rd_data;
    logic [31:0]       q0, q1;
    logic              wr_ready, clr_busy, clr_done;

    assign rd_addr = {rd1, rd0};
    assign q0 = rd_data[31:0];
    assign q1 = rd_data[63:32];

    regfile_mp #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .NUM_RD(NUM_RD),
        .BYPASS(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr0_en  (wr0_en),
        .wr0_addr(wr0_addr),
        .wr0_data(wr0_data),
        .wr1_en  (wr1_en),
        .wr1_addr(wr1_addr),
        .wr1_data(wr1_data),
        .wr_ready(wr_ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] mdl [DEPTH];
    int          m_left;
    int          m_pos;
    bit          m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        m_left = 0;
        m_pos  = 0;
        m_done = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        logic [31:0] v;
        v = mdl[a];
        if (m_left == 0) begin
            if (wr1_en && wr1_addr == a) v = wr1_data;
            else if (wr0_en && wr0_addr == a) v = wr0_data;
        end
        if (ZR && a == '0) v = '0;
        return v;
    endfunction

    task automatic settle_check();
        #4;
        chk("rd0", q0, exp_rd(rd0));
        chk("rd1", q1, exp_rd(rd1));
        chk("wr_ready", 32'(wr_ready), 32'(m_left == 0));
        chk("clr_busy", 32'(clr_busy), 32'(m_left > 0));
        chk("clr_done", 32'(clr_done), 32'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else if (m_left == 0) begin
            if (wr0_en && !(ZR && wr0_addr == '0)) mdl[wr0_addr] = wr0_data;
            if (wr1_en && !(ZR && wr1_addr == '0)) mdl[wr1_addr] = wr1_data;
            if (m_done) m_done = 1'b0;
            else if (clr_req) begin
                m_left = DEPTH;
                m_pos  = 0;
            end
        end else begin
            mdl[m_pos] = '0;
            m_pos++;
            m_left--;
            m_done = (m_left == 0);
        end
        #1;
    endtask

    typedef struct {
        logic          w0;
        logic [AW-1:0] a0;
        logic [31:0]   d0;
        logic          w1;
        logic [AW-1:0] a1;
        logic [31:0]   d1;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [31:0]   e0;
        logic [31:0]   e1;
    } vec_t;

    vec_t tbl [8];
    int   busy_cnt, nrdy_cnt, done_cnt;

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd5,  5'd7,  32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7, 32'h22222222, 5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  32'h22222222, 32'h22222222};
        tbl[4] = '{1'b1, 5'd10, 32'h12345678, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd10, 5'd9,  32'h12345678, 32'hA5A5A5A5};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd9,  5'd10, 32'hA5A5A5A5, 32'h12345678};
        tbl[6] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  R0V,          R0V};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  R0V,          32'h22222222};

        reset_n = 1'b0;
        {wr0_en, wr1_en, clr_req} = '0;
        {wr0_addr, wr1_addr, rd0, rd1} = '0;
        {wr0_data, wr1_data} = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        settle_check();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            rd0 = AW'(i);
            rd1 = AW'(i + 16);
            settle_check();
            chk("reset_rd0", q0, 32'h0);
            chk("reset_rd1", q1, 32'h0);
            tick();
        end

        for (int i = 0; i < 8; i++) begin
            wr0_en = tbl[i].w0; wr0_addr = tbl[i].a0; wr0_data = tbl[i].d0;
            wr1_en = tbl[i].w1; wr1_addr = tbl[i].a1; wr1_data = tbl[i].d1;
            rd0 = tbl[i].r0;    rd1 = tbl[i].r1;
            settle_check();
            chk($sformatf("vec%0d_rd0", i), q0, tbl[i].e0);
            chk($sformatf("vec%0d_rd1", i), q1, tbl[i].e1);
            tick();
        end
        wr0_en = 1'b0; wr1_en = 1'b0;

        for (int i = 0; i < 32; i++) begin
            wr0_en = 1'b1; wr0_addr = AW'(i); wr0_data = 32'(i + 1);
            settle_check();
            tick();
        end
        wr0_en = 1'b0;

        // clear request with a same-cycle write that must still commit
        clr_req = 1'b1;
        wr1_en = 1'b1; wr1_addr = 5'd20; wr1_data = 32'h77;
        settle_check();
        tick();
        clr_req = 1'b0; wr1_en = 1'b0;
        busy_cnt = 0; nrdy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            rd0 = (c == 10) ? 5'd3 : 5'd20;
            rd1 = (c == 10) ? 5'd31 : AW'(c);
            wr0_en = (c == 5);
            wr0_addr = 5'd2; wr0_data = 32'hBAD0BAD0;
            settle_check();
            if (c == 10) begin
                chk("midclr_reg3", q0, 32'h0);
                chk("midclr_reg31", q1, 32'd32);
            end
            busy_cnt += int'(clr_busy);
            nrdy_cnt += int'(!wr_ready);
            done_cnt += int'(clr_done);
            tick();
        end
        wr0_en = 1'b0;
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("wr_ready_low_cycles", 32'(nrdy_cnt), 32'd32);
        chk("clr_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd0 = AW'(i); rd1 = AW'(i + 16);
            settle_check();
            chk("postclr_rd0", q0, 32'h0);
            chk("postclr_rd1", q1, 32'h0);
            tick();
        end

        for (int i = 0; i < 32; i++) begin
            wr1_en = 1'b1; wr1_addr = AW'(i); wr1_data = $urandom | 32'h1;
            settle_check();
            tick();
        end
        wr1_en = 1'b0;
        clr_req = 1'b1;
        settle_check();
        tick();
        clr_req = 1'b0;
        repeat (10) begin
            settle_check();
            tick();
        end
        reset_n = 1'b0;
        model_reset();
        rd0 = 5'd31; rd1 = 5'd15;
        #1;
        chk("rstmid_busy", 32'(clr_busy), 32'h0);
        chk("rstmid_done", 32'(clr_done), 32'h0);
        chk("rstmid_ready", 32'(wr_ready), 32'h1);
        chk("rstmid_rd0", q0, 32'h0);
        settle_check();
        tick();
        reset_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 32; c++) begin
            rd0 = AW'(c); rd1 = AW'(31 - c);
            settle_check();
            chk("postrst_rd0", q0, 32'h0);
            done_cnt += int'(clr_done);
            tick();
        end
        chk("postrst_no_done", 32'(done_cnt), 32'h0);

        for (int n = 0; n < 800; n++) begin
            wr0_en   = 1'($urandom_range(0, 1));
            wr1_en   = 1'($urandom_range(0, 1));
            wr0_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr1_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr0_data = $urandom;
            wr1_data = $urandom;
            rd0      = ($urandom_range(0, 1) == 0) ? wr0_addr : AW'($urandom);
            rd1      = ($urandom_range(0, 1) == 0) ? wr1_addr : AW'($urandom);
            clr_req  = ($urandom_range(0, 59) == 0);
            settle_check();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
